// File: rtl/apb_txn_scheduler.sv
// APB-side sequencer of the AXI-to-APB bridge: round-robin pick between the write and
// read request FIFOs, one APB SETUP/ACCESS transfer at a time, result pushed to a response FIFO.
module apb_txn_scheduler #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              APB_clk,
    input  logic              APB_rst,
    input  logic              wr_req_empty,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [DATA_W-1:0] wr_req_data,
    output logic              wr_req_rinc,
    input  logic              rd_req_empty,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_req_rinc,
    input  logic              rd_data_full,
    output logic              rd_data_winc,
    output logic [DATA_W:0]   rd_data_wdata,
    input  logic              wr_resp_full,
    output logic              wr_resp_winc,
    output logic              wr_resp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR,
    output logic [1:0]        dbg_state_o
);

    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST_W = CW'(TO_LAST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CW-1:0]     wait_q, wait_d;

    logic wr_elig, rd_elig, grant_wr, grant_rd;
    logic wr_rinc_c, rd_rinc_c, rd_winc_c, wr_winc_c, psel_c, penable_c;

    assign wr_elig  = !wr_req_empty && !wr_resp_full;
    assign rd_elig  = !rd_req_empty && !rd_data_full;
    // On a tie the side that did not win last time goes first.
    assign grant_wr = wr_elig && (!rd_elig || !last_wr_q);
    assign grant_rd = rd_elig && (!wr_elig || last_wr_q);

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        wait_d    = wait_q;
        wr_rinc_c = 1'b0;
        rd_rinc_c = 1'b0;
        rd_winc_c = 1'b0;
        wr_winc_c = 1'b0;
        psel_c    = 1'b0;
        penable_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    wr_rinc_c = 1'b1;
                    paddr_d   = wr_req_addr;
                    pwdata_d  = wr_req_data;
                    pwrite_d  = 1'b1;
                    last_wr_d = 1'b1;
                    state_d   = SETUP;
                end else if (grant_rd) begin
                    rd_rinc_c = 1'b1;
                    paddr_d   = rd_req_addr;
                    pwdata_d  = '0;
                    pwrite_d  = 1'b0;
                    last_wr_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                psel_c  = 1'b1;
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                // PREADY is checked first so a completion on the last allowed cycle is not an abort.
                if (PREADY) begin
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    state_d = RESP;
                end else if ((TIMEOUT > 0) && (wait_q == TO_LAST_W)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                rd_winc_c = !pwrite_q;
                wr_winc_c = pwrite_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge APB_clk or posedge APB_rst) begin
        if (APB_rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
        end
    end

    // The pop is decoded from IDLE and the live flags, so it is masked while reset is held.
    assign wr_req_rinc   = wr_rinc_c && !APB_rst;
    assign rd_req_rinc   = rd_rinc_c && !APB_rst;
    assign rd_data_winc  = rd_winc_c;
    assign wr_resp_winc  = wr_winc_c;
    assign rd_data_wdata = {err_q, rdata_q};
    assign wr_resp_err   = err_q;
    assign PADDR         = paddr_q;
    assign PWRITE        = pwrite_q;
    assign PWDATA        = pwdata_q;
    assign PSEL          = psel_c;
    assign PENABLE       = penable_c;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_apb_txn_scheduler.sv
// Bench for apb_txn_scheduler: request FIFO and APB slave models, grant-order model,
// response scoreboard and directed plus randomized scenarios.
module tb_apb_txn_scheduler;

    localparam int TO = 8;

    logic        APB_clk = 1'b0;
    logic        APB_rst = 1'b1;
    logic        wr_req_empty = 1'b1;
    logic [31:0] wr_req_addr = '0;
    logic [31:0] wr_req_data = '0;
    logic        wr_req_rinc;
    logic        rd_req_empty = 1'b1;
    logic [31:0] rd_req_addr = '0;
    logic        rd_req_rinc;
    logic        rd_data_full = 1'b0;
    logic        rd_data_winc;
    logic [32:0] rd_data_wdata;
    logic        wr_resp_full = 1'b0;
    logic        wr_resp_winc;
    logic        wr_resp_err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic [1:0]  dbg_state;

    apb_txn_scheduler #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .APB_clk(APB_clk), .APB_rst(APB_rst),
        .wr_req_empty(wr_req_empty), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_rinc(wr_req_rinc),
        .rd_req_empty(rd_req_empty), .rd_req_addr(rd_req_addr), .rd_req_rinc(rd_req_rinc),
        .rd_data_full(rd_data_full), .rd_data_winc(rd_data_winc), .rd_data_wdata(rd_data_wdata),
        .wr_resp_full(wr_resp_full), .wr_resp_winc(wr_resp_winc), .wr_resp_err(wr_resp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state_o(dbg_state)
    );

    always #5 APB_clk = ~APB_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] rq_addr[$];
    logic        exp_order[$];   // 1 = write
    logic        obs_grants[$];
    logic [33:0] exp_q[$];       // {is_write, err, data}
    int          lat_q[$];
    int          acc_q[$];
    int          push_cyc_q[$];
    logic        model_last = 1'b1;

    int          wait_min = 0, wait_max = 0, err_pct = 0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_data = '0;

    bit          outstanding = 1'b0;
    bit          cur_wr = 1'b0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    int          grant_cyc = 0, acc_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request FIFO model: pop on the edge that sampled rinc, then present the new head.
    always @(posedge APB_clk) begin : fifo_model
        bit pw, pr;
        pw = wr_req_rinc;
        pr = rd_req_rinc;
        #1;
        if (pw && wq_addr.size() > 0) begin
            void'(wq_addr.pop_front());
            void'(wq_data.pop_front());
        end
        if (pr && rq_addr.size() > 0) void'(rq_addr.pop_front());
        wr_req_empty = (wq_addr.size() == 0);
        wr_req_addr  = wr_req_empty ? $urandom() : wq_addr[0];
        wr_req_data  = wr_req_empty ? $urandom() : wq_data[0];
        rd_req_empty = (rq_addr.size() == 0);
        rd_req_addr  = rd_req_empty ? $urandom() : rq_addr[0];
    end

    // APB slave: picks wait states per transfer and records the response the bridge owes.
    always @(posedge APB_clk) begin : apb_slave
        int sl_w, sl_cnt, a;
        bit sl_err;
        logic [31:0] sl_data;
        #1;
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom_range(1, 0));
        PRDATA  = $urandom();
        if (!APB_rst && PSEL && !PENABLE) begin
            sl_w    = $urandom_range(wait_max, wait_min);
            sl_err  = ($urandom_range(99, 0) < err_pct);
            sl_data = use_fixed ? fixed_data : $urandom();
            sl_cnt  = 0;
            if (sl_w >= TO) begin
                a = TO;
                exp_q.push_back({cur_wr, 1'b1, 32'h0});
            end else begin
                a = sl_w + 1;
                exp_q.push_back({cur_wr, sl_err, cur_wr ? 32'h0 : sl_data});
            end
            acc_q.push_back(a);
            lat_q.push_back(2 + a);
        end else if (!APB_rst && PSEL && PENABLE) begin
            if (sl_cnt == sl_w) begin
                PREADY  = 1'b1;
                PSLVERR = sl_err;
                PRDATA  = sl_data;
            end
            sl_cnt++;
        end
    end

    always @(negedge APB_clk) begin : monitor
        logic [33:0] e;
        int l, a;
        cyc++;
        if (APB_rst) begin
            outstanding = 1'b0;
            exp_q.delete();
            lat_q.delete();
            acc_q.delete();
        end else begin
            chk("protocol", {PENABLE && !PSEL, wr_req_rinc && rd_req_rinc,
                             (wr_req_rinc || rd_req_rinc) && outstanding}, 0);
            if (wr_req_rinc || rd_req_rinc) begin
                obs_grants.push_back(wr_req_rinc);
                if (exp_order.size() == 0) begin
                    chk("unexpected_grant", {wr_req_rinc, rd_req_rinc}, 0);
                end else begin
                    cur_wr = exp_order.pop_front();
                    chk("grant_side", {wr_req_rinc, rd_req_rinc}, {cur_wr, !cur_wr});
                    if (cur_wr && wq_addr.size() > 0) begin
                        cur_addr  = wq_addr[0];
                        cur_wdata = wq_data[0];
                    end else if (!cur_wr && rq_addr.size() > 0) begin
                        cur_addr  = rq_addr[0];
                        cur_wdata = 32'h0;
                    end
                end
                outstanding = 1'b1;
                grant_cyc   = cyc;
                acc_cnt     = 0;
            end
            if (PSEL && !PENABLE) begin
                chk("setup_cycle", cyc - grant_cyc, 1);
                chk("setup_paddr", PADDR, cur_addr);
                chk("setup_pwrite", PWRITE, cur_wr);
                chk("setup_pwdata", PWDATA, cur_wdata);
            end
            if (PSEL && PENABLE) begin
                if (acc_cnt == 0) chk("access_start", cyc - grant_cyc, 2);
                acc_cnt++;
                chk("access_paddr", PADDR, cur_addr);
                chk("access_pwrite", PWRITE, cur_wr);
                chk("access_pwdata", PWDATA, cur_wdata);
            end
            if (rd_data_winc || wr_resp_winc) begin
                if (!outstanding || exp_q.size() == 0) begin
                    chk("unexpected_push", {rd_data_winc, wr_resp_winc}, 0);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    a = acc_q.pop_front();
                    chk("push_side", {wr_resp_winc, rd_data_winc}, {e[33], !e[33]});
                    if (e[33]) chk("wr_resp_err", wr_resp_err, e[32]);
                    else       chk("rd_data_wdata", rd_data_wdata, e[32:0]);
                    chk("push_latency", cyc - grant_cyc, l);
                    chk("access_cycles", acc_cnt, a);
                end
                outstanding = 1'b0;
                push_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic add_wr(input logic [31:0] a, input logic [31:0] d);
        wq_addr.push_back(a);
        wq_data.push_back(d);
    endtask

    task automatic add_rd(input logic [31:0] a);
        rq_addr.push_back(a);
    endtask

    // Grant order from the arbitration rule alone: alternate while both sides hold requests.
    task automatic plan();
        int nw, nr;
        logic g;
        nw = wq_addr.size();
        nr = rq_addr.size();
        while (nw > 0 || nr > 0) begin
            if (nw > 0 && nr > 0) g = !model_last;
            else                  g = (nw > 0);
            exp_order.push_back(g);
            model_last = g;
            if (g) nw--; else nr--;
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_order.size() != 0 || outstanding || wq_addr.size() != 0 ||
                rq_addr.size() != 0) && n < budget) begin
            @(negedge APB_clk);
            #1;
            n++;
        end
        chk("drain_within_budget", n < budget, 1);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_psel"}, PSEL, 0);
        chk({p, "_penable"}, PENABLE, 0);
        chk({p, "_rinc"}, {wr_req_rinc, rd_req_rinc}, 0);
        chk({p, "_winc"}, {wr_resp_winc, rd_data_winc}, 0);
        chk({p, "_paddr"}, PADDR, 0);
        chk({p, "_pwdata"}, PWDATA, 0);
        chk({p, "_pwrite"}, PWRITE, 0);
        chk({p, "_rd_wdata"}, rd_data_wdata, 0);
        chk({p, "_wr_err"}, wr_resp_err, 0);
        chk({p, "_state"}, dbg_state, 0);
    endtask

    initial begin : stimulus
        int seen, n, nw, nr;

        // Reset held with a write already waiting: nothing may be popped.
        add_wr(32'h1000_0010, 32'hDEAD_BEEF);
        repeat (3) @(posedge APB_clk);
        @(negedge APB_clk);
        #1;
        check_zero("reset");
        plan();
        @(posedge APB_clk);
        #2;
        APB_rst = 1'b0;
        wait_done(40);

        // Three requests each side: strict R,W alternation, one push every 4 cycles.
        obs_grants.delete();
        push_cyc_q.delete();
        for (int i = 0; i < 3; i++) begin
            add_wr($urandom(), $urandom());
            add_rd($urandom());
        end
        plan();
        wait_done(100);
        chk("alt_grant_count", obs_grants.size(), 6);
        for (int i = 0; i < obs_grants.size() && i < 6; i++) chk("alt_order", obs_grants[i], i % 2);
        chk("alt_push_count", push_cyc_q.size(), 6);
        for (int i = 1; i < push_cyc_q.size(); i++)
            chk("alt_push_spacing", push_cyc_q[i] - push_cyc_q[i-1], 4);

        // Read with 3 wait states and a known PRDATA.
        wait_min = 3; wait_max = 3; use_fixed = 1'b1; fixed_data = 32'h1234_5678;
        add_rd(32'h2000_0040);
        plan();
        wait_done(40);
        wait_min = 0; wait_max = 0; use_fixed = 1'b0;

        // Read-data FIFO full: the read must wait, then go on the first free IDLE cycle.
        @(posedge APB_clk);
        #2;
        rd_data_full = 1'b1;
        add_rd(32'h3000_0000);
        seen = 0;
        repeat (12) begin
            @(negedge APB_clk);
            #1;
            if (rd_req_rinc || wr_req_rinc || PSEL) seen++;
        end
        chk("bp_stall", seen, 0);
        @(posedge APB_clk);
        #2;
        rd_data_full = 1'b0;
        exp_order.push_back(1'b0);
        model_last = 1'b0;
        @(negedge APB_clk);
        chk("bp_grant_next_idle", rd_req_rinc, 1);
        wait_done(40);

        // Timeout: PREADY withheld, then a normal transfer, then both sides of the boundary.
        wait_min = 20; wait_max = 20;
        add_rd(32'h4000_0000);
        plan();
        wait_done(60);
        wait_min = 0; wait_max = 0;
        add_wr(32'h4000_0004, 32'hCAFE_F00D);
        plan();
        wait_done(40);
        wait_min = TO - 1; wait_max = TO - 1;
        add_rd(32'h4000_0008);
        plan();
        wait_done(60);
        wait_min = TO; wait_max = TO;
        add_wr(32'h4000_000C, 32'h0BAD_0BAD);
        plan();
        wait_done(60);

        // Reset in the middle of ACCESS.
        wait_min = 30; wait_max = 30;
        add_rd(32'h5000_0000);
        plan();
        n = 0;
        while (!(PSEL && PENABLE) && n < 20) begin
            @(negedge APB_clk);
            #1;
            n++;
        end
        chk("rst_reached_access", PSEL && PENABLE, 1);
        #2;
        APB_rst = 1'b1;
        #1;
        check_zero("rst_access");
        wq_addr.delete(); wq_data.delete(); rq_addr.delete();
        exp_order.delete();
        model_last = 1'b1;
        wait_min = 0; wait_max = 0;
        repeat (3) @(posedge APB_clk);
        #2;
        APB_rst = 1'b0;
        obs_grants.delete();
        add_wr(32'h6000_0000, 32'h1111_2222);
        add_rd(32'h6000_0004);
        plan();
        wait_done(60);
        chk("post_rst_grants", obs_grants.size(), 2);
        if (obs_grants.size() > 0) chk("post_rst_first_is_read", obs_grants[0], 0);

        // Randomized rounds: random mixes, wait states across the timeout boundary, slave errors.
        wait_min = 0; wait_max = 10; err_pct = 30;
        for (int r = 0; r < 6; r++) begin
            nw = $urandom_range(4, 0);
            nr = $urandom_range(4, 0);
            for (int i = 0; i < nw; i++) add_wr($urandom(), $urandom());
            for (int i = 0; i < nr; i++) add_rd($urandom());
            plan();
            wait_done(300);
        end

        repeat (4) @(posedge APB_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "bench exceeded its time limit");
    end

endmodule

// File: doc/apb_txn_scheduler.md
# apb_txn_scheduler

APB-clock-domain sequencer for the AXI-to-APB bridge. Arbitrates between the write-request and read-request async FIFOs (round-robin), pops one request at a time, runs the APB SETUP/ACCESS protocol, and pushes the result into the read-data FIFO or write-response FIFO. Handshaking toward the AXI side goes only through these FIFOs.

## Interface

- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 0, max ACCESS cycles without PREADY; 0 disables timeout
- APB_clk  in  1  APB clock; all logic on rising edge
- APB_rst  in  1  asynchronous, active-high reset
- wr_req_empty  in  1  write-request FIFO empty
- wr_req_addr  in  ADDR_W  write-request FIFO head address (show-ahead, valid when !empty)
- wr_req_data  in  DATA_W  write-request FIFO head data
- wr_req_rinc  out  1  write-request FIFO pop, one-cycle pulse
- rd_req_empty  in  1  read-request FIFO empty
- rd_req_addr  in  ADDR_W  read-request FIFO head address
- rd_req_rinc  out  1  read-request FIFO pop, one-cycle pulse
- rd_data_full  in  1  read-data FIFO full
- rd_data_winc  out  1  read-data FIFO push, one-cycle pulse
- rd_data_wdata  out  DATA_W+1  {err, data} pushed to read-data FIFO
- wr_resp_full  in  1  write-response FIFO full
- wr_resp_winc  out  1  write-response FIFO push, one-cycle pulse
- wr_resp_err  out  1  error bit pushed with wr_resp_winc
- PADDR  out  ADDR_W;  PWRITE  out  1;  PSEL  out  1;  PENABLE  out  1;  PWDATA  out  DATA_W
- PRDATA  in  DATA_W;  PREADY  in  1;  PSLVERR  in  1

## Operation

- FSM states: IDLE, SETUP, ACCESS, RESP.
- Eligibility, evaluated only in IDLE:
  - Write is eligible when !wr_req_empty && !wr_resp_full.
  - Read is eligible when !rd_req_empty && !rd_data_full.
- Arbitration:
  - If only one side is eligible, grant it.
  - If both are eligible, grant the side not granted last (last_grant register).
  - last_grant resets to WRITE, so the first tie goes to READ.
- Grant cycle (IDLE):
  - Pulse the granted FIFO's rinc.
  - Latch the head addr (and data, for writes) into PADDR/PWDATA.
  - Set PWRITE; update last_grant; go to SETUP.
  - For a read, PWDATA = 0.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable from SETUP through the end of ACCESS.
- ACCESS exits on PREADY=1: latch PRDATA (reads) and PSLVERR as err, deassert PSEL/PENABLE, go to RESP.
- Timeout (TIMEOUT>0):
  - Wait counter starts at 0 on ACCESS entry and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT, abort: err=1, read data=0, PSEL/PENABLE drop, go to RESP.
  - PREADY in the same cycle as the timeout wins (normal completion).
  - Counter width is clog2(TIMEOUT+1), minimum 1.
- RESP:
  - Pulse rd_data_winc with {err, data}, or wr_resp_winc with err.
  - Return to IDLE.
  - Output-FIFO space was checked at grant and this block is its only writer, so the push never overflows.
- RESP exists so the full flags reflect the push before the next eligibility check.
- Reset (asynchronous, any state):
  - FSM returns to IDLE; all outputs go to 0; last_grant = WRITE; counter = 0.
  - A request popped before reset is dropped with no response. Reset is a whole-bridge event only.

## Timing

- Reset value of every output: 0.
- Grant-to-push latency with zero wait states: 4 cycles (IDLE grant, SETUP, ACCESS, RESP). Each PREADY=0 cycle adds one.
- Maximum throughput: one APB transfer per 4 cycles.
- Rules:
  - Never more than one outstanding transfer.
  - rinc/winc pulses never last more than 1 cycle.
  - PSEL never drops between SETUP and ACCESS.
  - PENABLE is never high outside ACCESS.
- Empty/full flags are sampled only in IDLE. Changes during a transfer have no effect until the next IDLE.

## Test plan

- Single write: addr 0x1000_0010, data 0xDEAD_BEEF, PREADY tied 1.
  - Expect rinc at cycle 0, SETUP at cycle 1, ACCESS at cycle 2.
  - wr_resp_winc=1 with err=0 at cycle 3.
- Read with 3 wait states: PRDATA=0x1234_5678.
  - Expect PENABLE high for 4 cycles.
  - rd_data_wdata = {0, 0x1234_5678} pushed 1 cycle after PREADY.
- Both FIFOs hold 3 entries each, both continuously eligible.
  - Expect APB order R, W, R, W, R, W.
  - Exactly 6 pushes, 4 cycles apart.
- Backpressure: rd_data_full=1 with a read pending and the write FIFO empty.
  - Expect no rinc and PSEL stays 0.
  - Deassert full: the read is granted the next IDLE cycle.
- TIMEOUT=8, PREADY held 0.
  - Expect ACCESS for 8 cycles, then push with err=1 and data=0.
  - Next transfer proceeds normally.
- Assert APB_rst during ACCESS.
  - Expect PSEL/PENABLE/all pulses at 0 immediately.
  - After release: IDLE, and the first tie goes to READ.
